census_wta_select: RTL and testbench
====================================

Name: census_wta_select

Overview:
- Downstream of the per-disparity Hamming-cost popcount stage in the census stereo pipeline.
- Consumes one matching cost per clock, in disparity order 0..NUM_DISP-1 for each pixel.
- Tracks the running minimum cost and emits the winning disparity, with its cost, once per pixel (winner-take-all).
- Output feeds the disparity-map writer.

Parameters:
- COST_W, 5, width of incoming cost; matches the popcount stage output width.
- NUM_DISP, 16, number of candidate disparities per pixel; must be ≥2.
- DISP_W, 4, width of the disparity index; ceil(log2(NUM_DISP)).
- UNIQ_THRESH, 2, minimum margin between best and second-best cost. Used only with the optional feature.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high; clears all state.
- cost_in, input, COST_W, Hamming cost for the current disparity.
- cost_valid, input, 1, cost_in is valid this cycle.
- disp_out, output, DISP_W, winning disparity of the last completed pixel.
- min_cost_out, output, COST_W, cost of the winning disparity.
- disp_valid, output, 1, single-cycle strobe: disp_out and min_cost_out are new.
- disp_ambig, output, 1, winner not unique. Meaningful only with UNIQUENESS_CHECK_EN.

Behaviour:
- Reset:
  - disp_out=0, min_cost_out=0, disp_valid=0, disp_ambig=0.
  - Internal disparity counter d_cnt=0; running min=all-ones; running best index=0.
  - Reset mid-pixel discards the partial pixel. The next valid cost is treated as disparity 0.
- Disparity counter:
  - d_cnt advances only on cost_valid=1.
  - Wraps from NUM_DISP-1 to 0.
  - Bubbles (cost_valid=0) hold all state.
- Compare rule on a valid cost:
  - If d_cnt==0: running min=cost_in and best index=0, unconditionally. Stale data from the previous pixel is ignored.
  - Otherwise: update only if cost_in < running min (strict). On ties the lower disparity wins.
- Completion:
  - On the valid cycle with d_cnt==NUM_DISP-1, the final compare (including this cost) is registered into disp_out/min_cost_out.
  - disp_valid=1 on the following cycle only; latency is 1 clock after the last cost.
- Output hold: disp_out and min_cost_out hold their value until the next completion. disp_valid returns to 0 after one cycle.
- Back-to-back pixels: disparity 0 of the next pixel may arrive on the cycle right after the last cost. No dead cycle is required, and sustained throughput is one pixel per NUM_DISP valid cycles.
- Arithmetic: costs are unsigned. A cost of all-ones is legal and must still win if every disparity has that cost (best index 0).
- No backpressure: the downstream stage must accept every disp_valid strobe.

Optional Feature:
- Macro: UNIQUENESS_CHECK_EN.
- When defined:
  - A second-best cost is tracked alongside the minimum.
  - When the minimum is replaced, second-best takes the old minimum. Otherwise second-best takes min(second-best, cost_in).
  - At completion, disp_ambig=1 if (second_best - min) < UNIQ_THRESH, computed unsigned with no underflow because second_best ≥ min.
  - disp_ambig is registered alongside disp_out and updates under the same timing.
- When not defined: the disp_ambig port still exists and is driven constant 0. No second-best logic is synthesized.

Decomposition:
- Shared package stereo_pkg holds COST_W, DISP_W, NUM_DISP, and the COST_MAX constant (all-ones). The popcount stage and this block import the same values.
- One sub-module, wta_compare:
  - Combinational compare-select.
  - Inputs: current min, current best index, cost_in, d_cnt, first flag.
  - Outputs: next min and next best index.
  - Under UNIQUENESS_CHECK_EN it also produces next second-best.
- The top level owns d_cnt, the state registers and the output registers.

Test Plan:
- Reset, then costs 9,7,7,3,8,... with 3 at d=3 and all others >3, 16 back-to-back valids -> disp_valid one cycle after d=15; disp_out=3, min_cost_out=3.
- Tie: all 16 costs = 5 -> disp_out=0, min_cost_out=5. Then a pixel with costs 31 everywhere except 2 at d=15 -> disp_out=15, min_cost_out=2.
- Bubbles: same stream as the first scenario with cost_valid low on alternate cycles -> identical result; disp_valid exactly once, one cycle after the 16th valid.
- Back-to-back pixels with the minimum at d=0 for the second pixel (cost 1) -> second result disp_out=0, min_cost_out=1; no carry-over from the first pixel.
- Reset asserted after 7 valid costs, then a full fresh pixel with min 4 at d=10 -> no disp_valid from the aborted pixel; then disp_out=10, min_cost_out=4.
- With UNIQUENESS_CHECK_EN, UNIQ_THRESH=2:
  - Min 4 and second-best 5 -> disp_ambig=1.
  - Min 4 and second-best 6 -> disp_ambig=0.
  - Without the macro -> disp_ambig stays 0.

Source files
------------

// File: rtl/stereo_pkg.sv
// Shared census stereo constants: cost/disparity widths and the all-ones cost value.
package stereo_pkg;

  localparam int COST_W      = 5;
  localparam int NUM_DISP    = 16;
  localparam int DISP_W      = $clog2(NUM_DISP);
  localparam int UNIQ_THRESH = 2;

  localparam logic [COST_W-1:0] COST_MAX = {COST_W{1'b1}};

  function automatic logic is_last_disp(input logic [DISP_W-1:0] d);
    return d == DISP_W'(NUM_DISP - 1);
  endfunction

endpackage

// File: rtl/wta_compare.sv
// Combinational winner-take-all compare-select for one incoming cost.
// Second-best tracking is only present when UNIQUENESS_CHECK_EN is defined.
module wta_compare
  import stereo_pkg::*;
(
  input  logic [COST_W-1:0] cur_min,
  input  logic [DISP_W-1:0] cur_best,
`ifdef UNIQUENESS_CHECK_EN
  input  logic [COST_W-1:0] cur_second,
  output logic [COST_W-1:0] next_second,
`endif
  input  logic [COST_W-1:0] cost_in,
  input  logic [DISP_W-1:0] d_cnt,
  input  logic              first,
  output logic [COST_W-1:0] next_min,
  output logic [DISP_W-1:0] next_best
);

  // Disparity 0 restarts the search; later costs must be strictly lower to win,
  // so ties keep the lower disparity.
  always_comb begin
    next_min  = cur_min;
    next_best = cur_best;
`ifdef UNIQUENESS_CHECK_EN
    next_second = cur_second;
`endif
    if (first) begin
      next_min  = cost_in;
      next_best = '0;
`ifdef UNIQUENESS_CHECK_EN
      next_second = COST_MAX;
`endif
    end else if (cost_in < cur_min) begin
      next_min  = cost_in;
      next_best = d_cnt;
`ifdef UNIQUENESS_CHECK_EN
      next_second = cur_min;
`endif
    end else begin
`ifdef UNIQUENESS_CHECK_EN
      if (cost_in < cur_second) next_second = cost_in;
`endif
    end
  end

endmodule

// File: rtl/census_wta_select.sv
// Winner-take-all disparity select: one cost per valid cycle, one result per pixel.
// Optional uniqueness flag on disp_ambig via UNIQUENESS_CHECK_EN.
module census_wta_select
  import stereo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [COST_W-1:0] cost_in,
  input  logic              cost_valid,
  output logic [DISP_W-1:0] disp_out,
  output logic [COST_W-1:0] min_cost_out,
  output logic              disp_valid,
  output logic              disp_ambig
);

  logic [DISP_W-1:0] d_cnt;
  logic [COST_W-1:0] run_min;
  logic [DISP_W-1:0] run_best;
  logic [COST_W-1:0] nx_min;
  logic [DISP_W-1:0] nx_best;
  logic              last;

`ifdef UNIQUENESS_CHECK_EN
  logic [COST_W-1:0] run_second;
  logic [COST_W-1:0] nx_second;
  logic              nx_ambig;
`endif

  assign last = is_last_disp(d_cnt);

  wta_compare u_cmp (
    .cur_min     (run_min),
    .cur_best    (run_best),
`ifdef UNIQUENESS_CHECK_EN
    .cur_second  (run_second),
    .next_second (nx_second),
`endif
    .cost_in     (cost_in),
    .d_cnt       (d_cnt),
    .first       (d_cnt == '0),
    .next_min    (nx_min),
    .next_best   (nx_best)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      d_cnt    <= '0;
      run_min  <= COST_MAX;
      run_best <= '0;
    end else if (cost_valid) begin
      d_cnt    <= last ? '0 : d_cnt + 1'b1;
      run_min  <= nx_min;
      run_best <= nx_best;
    end
  end

  // The final compare goes straight to the output registers so the result
  // appears one clock after the last cost, with no dead cycle between pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_out     <= '0;
      min_cost_out <= '0;
      disp_valid   <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      if (cost_valid && last) begin
        disp_out     <= nx_best;
        min_cost_out <= nx_min;
        disp_valid   <= 1'b1;
      end
    end
  end

`ifdef UNIQUENESS_CHECK_EN
  assign nx_ambig = (nx_second - nx_min) < COST_W'(UNIQ_THRESH);

  always_ff @(posedge clk) begin
    if (reset) begin
      run_second <= COST_MAX;
      disp_ambig <= 1'b0;
    end else if (cost_valid) begin
      run_second <= nx_second;
      if (last) disp_ambig <= nx_ambig;
    end
  end
`else
  assign disp_ambig = 1'b0;
`endif

endmodule

// File: tb/tb_census_wta_select.sv
// Scoreboard bench for census_wta_select: directed pixels with hand-computed winners.
module tb_census_wta_select;
  import stereo_pkg::*;

  typedef struct {
    int disp;
    int cost;
    int ambig;
    int cycle;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [COST_W-1:0] cost_in = '0;
  logic              cost_valid = 1'b0;
  logic [DISP_W-1:0] disp_out;
  logic [COST_W-1:0] min_cost_out;
  logic              disp_valid;
  logic              disp_ambig;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  census_wta_select dut (
    .clk          (clk),
    .reset        (reset),
    .cost_in      (cost_in),
    .cost_valid   (cost_valid),
    .disp_out     (disp_out),
    .min_cost_out (min_cost_out),
    .disp_valid   (disp_valid),
    .disp_ambig   (disp_ambig)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every disp_valid strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (disp_valid) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_disp_valid", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checkOutput("disp_out", int'(disp_out), e.disp);
        checkOutput("min_cost_out", int'(min_cost_out), e.cost);
        checkOutput("disp_ambig", int'(disp_ambig), e.ambig);
        checkOutput("valid_cycle", cycle, e.cycle);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 cost_valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [COST_W-1:0] costs [NUM_DISP], input bit gap,
                               input int exp_disp, input int exp_cost, input int exp_amb);
    exp_t e;
    for (int i = 0; i < NUM_DISP; i++) begin
      @(posedge clk);
      #1;
      cost_in    = costs[i];
      cost_valid = 1'b1;
      if (i == NUM_DISP - 1) begin
        e.disp  = exp_disp;
        e.cost  = exp_cost;
`ifdef UNIQUENESS_CHECK_EN
        e.ambig = exp_amb;
`else
        e.ambig = 0;
`endif
        e.cycle = cycle + 1;
        expq.push_back(e);
      end else if (gap) begin
        idle(1);
      end
    end
  endtask

  logic [COST_W-1:0] pa [NUM_DISP];
  logic [COST_W-1:0] pt [NUM_DISP];
  logic [COST_W-1:0] pc [NUM_DISP];
  logic [COST_W-1:0] pd [NUM_DISP];
  logic [COST_W-1:0] pe [NUM_DISP];
  logic [COST_W-1:0] pf [NUM_DISP];

  initial begin
    // A: 9,7,7,3,8..19 -> winner d=3 cost 3, second-best 7
    pa[0] = 9; pa[1] = 7; pa[2] = 7; pa[3] = 3;
    for (int i = 4; i < NUM_DISP; i++) pa[i] = COST_W'(i + 4);
    for (int i = 0; i < NUM_DISP; i++) pt[i] = 5;
    for (int i = 0; i < NUM_DISP; i++) pc[i] = 31;
    pc[15] = 2;
    for (int i = 0; i < NUM_DISP; i++) pd[i] = 20;
    pd[0] = 1;
    for (int i = 0; i < NUM_DISP; i++) pe[i] = 9;
    pe[3] = 5; pe[10] = 4;
    for (int i = 0; i < NUM_DISP; i++) pf[i] = 12;
    pf[2] = 6; pf[10] = 4;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_disp_out", int'(disp_out), 0);
    checkOutput("reset_min_cost", int'(min_cost_out), 0);
    checkOutput("reset_valid", int'(disp_valid), 0);
    checkOutput("reset_ambig", int'(disp_ambig), 0);

    applyStimulus(pa, 1'b0, 3, 3, 0);
    idle(4);
    checkOutput("hold_disp_out", int'(disp_out), 3);
    checkOutput("hold_min_cost", int'(min_cost_out), 3);

    applyStimulus(pt, 1'b0, 0, 5, 1);
    applyStimulus(pc, 1'b0, 15, 2, 0);
    idle(2);

    applyStimulus(pa, 1'b1, 3, 3, 0);
    idle(2);

    applyStimulus(pc, 1'b0, 15, 2, 0);
    applyStimulus(pd, 1'b0, 0, 1, 0);
    idle(3);

    // Aborted pixel: zeros would otherwise win at d=0
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1 cost_in = '0;
      cost_valid = 1'b1;
    end
    @(posedge clk);
    #1 cost_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_disp_out", int'(disp_out), 0);
    checkOutput("midreset_min_cost", int'(min_cost_out), 0);

    applyStimulus(pe, 1'b0, 10, 4, 1);
    applyStimulus(pf, 1'b0, 10, 4, 0);
    idle(5);

    checkOutput("pending_results", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
